keccak_sponge_controller: RTL and testbench



---
 rtl/keccak_sponge_controller_pkg.sv | 25 ++
 rtl/keccak_sponge_controller_if.sv | 38 +++
 rtl/keccak_sponge_controller_round_counter.sv | 39 +++
 rtl/keccak_sponge_controller.sv | 112 +++++++++++
 tb/tb_keccak_sponge_controller.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_sponge_controller_pkg.sv
`default_nettype none
// =============================================================================
// keccak_sponge_controller_pkg : sponge state type, defaults, counter-width helper
// Revision 1.0
// =============================================================================
package keccak_sponge_controller_pkg;

  localparam int N_R_DEFAULT = 24;
  localparam int RPC_DEFAULT = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ABSORB  = 3'd1,
    S_PERMUT  = 3'd2,
    S_SQUEEZE = 3'd3,
    S_DONE    = 3'd4
  } sponge_state_t;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_sponge_controller_if.sv
`default_nettype none
// =============================================================================
// keccak_sponge_controller_if : front-end / datapath handshake bundle of the sponge controller
// Revision 1.0
// =============================================================================
interface keccak_sponge_controller_if #(
  parameter int BLK_W = 8,
  parameter int IDX_W = 5
);

  logic             START;
  logic [BLK_W-1:0] NUM_ABSORB;
  logic [BLK_W-1:0] NUM_SQUEEZE;
  logic             DIN_VALID;
  logic             DIN_READY;
  logic             DOUT_VALID;
  logic             DOUT_READY;
  logic             CLEAR_STATE;
  logic             ABSORB_EN;
  logic             ENABLE_ROUND;
  logic [IDX_W-1:0] ROUND_IDX;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, NUM_ABSORB, NUM_SQUEEZE, DIN_VALID, DOUT_READY,
    input  DIN_READY, DOUT_VALID, CLEAR_STATE, ABSORB_EN, ENABLE_ROUND,
           ROUND_IDX, BUSY, DONE
  );

  modport slave (
    input  START, NUM_ABSORB, NUM_SQUEEZE, DIN_VALID, DOUT_READY,
    output DIN_READY, DOUT_VALID, CLEAR_STATE, ABSORB_EN, ENABLE_ROUND,
           ROUND_IDX, BUSY, DONE
  );

endinterface
`default_nettype wire

// File: rtl/keccak_sponge_controller_round_counter.sv
`default_nettype none
// =============================================================================
// keccak_round_counter : RPC-stepped round index with saturating last flag
// Revision 1.0
// =============================================================================
module keccak_round_counter
  import keccak_sponge_controller_pkg::*;
#(
  parameter int N_R = N_R_DEFAULT,
  parameter int RPC = RPC_DEFAULT
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   en,
  input  wire logic                   clr,
  output logic [$clog2(N_R)-1:0]      round_idx,
  output logic                        last
);

  localparam int P     = N_R / RPC;
  localparam int RND_W = cnt_width(P);
  localparam int IDX_W = $clog2(N_R);

  logic [RND_W-1:0] rnd;

  assign last      = (rnd == RND_W'(P - 1));
  assign round_idx = IDX_W'(int'(rnd) * RPC);

  // Holds on the last value; the controller clears it before the next permutation.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rnd <= '0;
    end else if (en && !last) begin
      rnd <= rnd + RND_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/keccak_sponge_controller.sv
`default_nettype none
// =============================================================================
// keccak_sponge_controller : clear/absorb/permute/squeeze sequencer for the KECCAK core
// Revision 1.0
// =============================================================================
module keccak_sponge_controller
  import keccak_sponge_controller_pkg::*;
#(
  parameter int N_R   = N_R_DEFAULT,
  parameter int RPC   = RPC_DEFAULT,
  parameter int BLK_W = 8
) (
  input  wire logic                  CLK,
  input  wire logic                  RESET,
  keccak_sponge_controller_if.slave  bus
);

  localparam int IDX_W = $clog2(N_R);

  if ((RPC < 1) || ((N_R % RPC) != 0)) begin : g_rpc_check
    $error("keccak_sponge_controller: N_R must be a positive multiple of RPC");
  end

  sponge_state_t    state;
  logic [BLK_W-1:0] num_a;
  logic [BLK_W-1:0] num_s;
  logic [BLK_W-1:0] abs_cnt;
  logic [BLK_W-1:0] sq_cnt;
  logic [BLK_W-1:0] sq_next;
  logic             sq_final;
  logic             din_hs;
  logic             dout_hs;
  logic             rnd_clr;
  logic             rnd_last;
  logic [IDX_W-1:0] rnd_idx;

  assign din_hs   = (state == S_ABSORB) && bus.DIN_VALID;
  assign dout_hs  = (state == S_SQUEEZE) && bus.DOUT_READY;
  assign sq_next  = sq_cnt + BLK_W'(1);
  assign sq_final = (sq_next == num_s);
  assign rnd_clr  = din_hs || (dout_hs && !sq_final);

  keccak_round_counter #(
    .N_R (N_R),
    .RPC (RPC)
  ) u_round_counter (
    .clk       (CLK),
    .rst       (RESET),
    .en        (state == S_PERMUT),
    .clr       (rnd_clr),
    .round_idx (rnd_idx),
    .last      (rnd_last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      num_a   <= '0;
      num_s   <= '0;
      abs_cnt <= '0;
      sq_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            // A zero block count still runs one block.
            num_a   <= (bus.NUM_ABSORB  == '0) ? BLK_W'(1) : bus.NUM_ABSORB;
            num_s   <= (bus.NUM_SQUEEZE == '0) ? BLK_W'(1) : bus.NUM_SQUEEZE;
            abs_cnt <= '0;
            sq_cnt  <= '0;
            state   <= S_ABSORB;
          end
        end
        S_ABSORB: begin
          if (bus.DIN_VALID) begin
            abs_cnt <= abs_cnt + BLK_W'(1);
            state   <= S_PERMUT;
          end
        end
        S_PERMUT: begin
          if (rnd_last) begin
            state <= (abs_cnt != num_a) ? S_ABSORB : S_SQUEEZE;
          end
        end
        S_SQUEEZE: begin
          if (bus.DOUT_READY) begin
            sq_cnt <= sq_next;
            state  <= sq_final ? S_DONE : S_PERMUT;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // CLEAR_STATE and ABSORB_EN are the only Mealy terms.
  assign bus.CLEAR_STATE  = (state == S_IDLE) && bus.START;
  assign bus.ABSORB_EN    = din_hs;
  assign bus.DIN_READY    = (state == S_ABSORB);
  assign bus.ENABLE_ROUND = (state == S_PERMUT);
  assign bus.ROUND_IDX    = (state == S_PERMUT) ? rnd_idx : '0;
  assign bus.DOUT_VALID   = (state == S_SQUEEZE);
  assign bus.BUSY         = (state != S_IDLE);
  assign bus.DONE         = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_keccak_sponge_controller.sv
`default_nettype none
// =============================================================================
// tb_keccak_sponge_controller : directed cycle-by-cycle check of two controller instances
// Revision 1.0
// =============================================================================
module tb_keccak_sponge_controller;

  logic clk;
  logic rst;

  keccak_sponge_controller_if #(.BLK_W(8), .IDX_W(5)) if1 ();
  keccak_sponge_controller_if #(.BLK_W(8), .IDX_W(5)) if4 ();

  keccak_sponge_controller #(.N_R(24), .RPC(1), .BLK_W(8)) dut1 (
    .CLK(clk), .RESET(rst), .bus(if1));
  keccak_sponge_controller #(.N_R(24), .RPC(4), .BLK_W(8)) dut4 (
    .CLK(clk), .RESET(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {CLEAR, ABSORB_EN, ENABLE_ROUND, ROUND_IDX[4:0], DIN_READY, DOUT_VALID, BUSY, DONE}
  logic [11:0] obs1;
  logic [11:0] obs4;
  assign obs1 = {if1.CLEAR_STATE, if1.ABSORB_EN, if1.ENABLE_ROUND, if1.ROUND_IDX,
                 if1.DIN_READY, if1.DOUT_VALID, if1.BUSY, if1.DONE};
  assign obs4 = {if4.CLEAR_STATE, if4.ABSORB_EN, if4.ENABLE_ROUND, if4.ROUND_IDX,
                 if4.DIN_READY, if4.DOUT_VALID, if4.BUSY, if4.DONE};

  typedef struct {
    logic [11:0] word;
    bit          start;
    bit          din_valid;
    bit          dout_ready;
    logic [7:0]  na;
    logic [7:0]  ns;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [11:0] mk(bit clr, bit aen, bit en, int idx,
                                     bit drdy, bit dval, bit busy, bit done);
    logic [4:0] i5;
    i5 = 5'(idx);
    return {clr, aen, en, i5, drdy, dval, busy, done};
  endfunction

  function automatic ent_t ent(logic [11:0] w, bit st, bit dv, bit dr,
                               logic [7:0] na, logic [7:0] ns);
    ent_t e;
    e.word = w; e.start = st; e.din_valid = dv; e.dout_ready = dr;
    e.na = na; e.ns = ns;
    return e;
  endfunction

  // Append the expected timeline of one run: a/s effective blocks, p cycles per permutation.
  task automatic build(input int a, input int s, input int p, input int rpc,
                       input int astall, input int sstall, input bit tail_idle,
                       input logic [7:0] na, input logic [7:0] ns);
    q.push_back(ent(mk(1,0,0,0,0,0,0,0), 1, 1, 1, na, ns));
    for (int b = 0; b < a; b++) begin
      if (b == 0)
        for (int k = 0; k < astall; k++)
          q.push_back(ent(mk(0,0,0,0,1,0,1,0), 0, 0, 1, na, ns));
      q.push_back(ent(mk(0,1,0,0,1,0,1,0), 0, 1, 1, na, ns));
      for (int r = 0; r < p; r++)
        q.push_back(ent(mk(0,0,1,r*rpc,0,0,1,0), 0, 1, 1, na, ns));
    end
    for (int b = 0; b < s; b++) begin
      if (b == 0)
        for (int k = 0; k < sstall; k++)
          q.push_back(ent(mk(0,0,0,0,0,1,1,0), 0, 1, 0, na, ns));
      q.push_back(ent(mk(0,0,0,0,0,1,1,0), 0, 1, 1, na, ns));
      if (b < s - 1)
        for (int r = 0; r < p; r++)
          q.push_back(ent(mk(0,0,1,r*rpc,0,0,1,0), 0, 1, 1, na, ns));
    end
    q.push_back(ent(mk(0,0,0,0,0,0,1,1), 0, 1, 1, na, ns));
    if (tail_idle)
      q.push_back(ent(12'h000, 0, 1, 1, na, ns));
  endtask

  task automatic idle_inputs();
    if1.START = 0; if1.DIN_VALID = 0; if1.DOUT_READY = 0;
    if1.NUM_ABSORB = 0; if1.NUM_SQUEEZE = 0;
    if4.START = 0; if4.DIN_VALID = 0; if4.DOUT_READY = 0;
    if4.NUM_ABSORB = 0; if4.NUM_SQUEEZE = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (obs1 !== 12'h000) begin
      n_err++; $display("FAIL reset_dut1 got %h want %h", obs1, 12'h000);
    end
    n_cmp++;
    if (obs4 !== 12'h000) begin
      n_err++; $display("FAIL reset_dut4 got %h want %h", obs4, 12'h000);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if (obs1 !== 12'h000) begin
      n_err++; $display("FAIL post_reset_dut1 got %h want %h", obs1, 12'h000);
    end
    n_cmp++;
    if (obs4 !== 12'h000) begin
      n_err++; $display("FAIL post_reset_dut4 got %h want %h", obs4, 12'h000);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_minimal();
    q.delete();
    build(1, 1, 24, 1, 0, 0, 1, 8'd1, 8'd1);
    for (int i = 0; i < q.size(); i++) begin
      if1.START = q[i].start; if1.DIN_VALID = q[i].din_valid;
      if1.DOUT_READY = q[i].dout_ready;
      if1.NUM_ABSORB = q[i].na; if1.NUM_SQUEEZE = q[i].ns;
      @(negedge clk);
      n_cmp++;
      if (obs1 !== q[i].word) begin
        n_err++; $display("FAIL minimal cyc %0d got %h want %h", i, obs1, q[i].word);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_multi_block();
    q.delete();
    build(3, 2, 6, 4, 0, 0, 1, 8'd3, 8'd2);
    for (int i = 0; i < q.size(); i++) begin
      if4.START = q[i].start; if4.DIN_VALID = q[i].din_valid;
      if4.DOUT_READY = q[i].dout_ready;
      if4.NUM_ABSORB = q[i].na; if4.NUM_SQUEEZE = q[i].ns;
      @(negedge clk);
      n_cmp++;
      if (obs4 !== q[i].word) begin
        n_err++; $display("FAIL multi_block cyc %0d got %h want %h", i, obs4, q[i].word);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_stalls();
    q.delete();
    build(1, 1, 6, 4, 5, 3, 1, 8'd1, 8'd1);
    for (int i = 0; i < q.size(); i++) begin
      if4.START = q[i].start; if4.DIN_VALID = q[i].din_valid;
      if4.DOUT_READY = q[i].dout_ready;
      if4.NUM_ABSORB = q[i].na; if4.NUM_SQUEEZE = q[i].ns;
      @(negedge clk);
      n_cmp++;
      if (obs4 !== q[i].word) begin
        n_err++; $display("FAIL stalls cyc %0d got %h want %h", i, obs4, q[i].word);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_zero_counts();
    q.delete();
    build(1, 1, 24, 1, 0, 0, 1, 8'd0, 8'd0);
    for (int i = 0; i < q.size(); i++) begin
      if1.START = q[i].start; if1.DIN_VALID = q[i].din_valid;
      if1.DOUT_READY = q[i].dout_ready;
      if1.NUM_ABSORB = q[i].na; if1.NUM_SQUEEZE = q[i].ns;
      @(negedge clk);
      n_cmp++;
      if (obs1 !== q[i].word) begin
        n_err++; $display("FAIL zero_counts cyc %0d got %h want %h", i, obs1, q[i].word);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    q.delete();
    build(1, 1, 24, 1, 0, 0, 1, 8'd1, 8'd1);
    // Entry 12 is the permutation cycle showing ROUND_IDX = 10.
    for (int i = 0; i <= 12; i++) begin
      if1.START = q[i].start; if1.DIN_VALID = q[i].din_valid;
      if1.DOUT_READY = q[i].dout_ready;
      if1.NUM_ABSORB = q[i].na; if1.NUM_SQUEEZE = q[i].ns;
      rst = (i == 12);
      @(negedge clk);
      n_cmp++;
      if (obs1 !== q[i].word) begin
        n_err++; $display("FAIL reset_mid pre cyc %0d got %h want %h", i, obs1, q[i].word);
      end
      @(posedge clk); #1;
    end
    rst = 0;
    if1.START = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs1 !== 12'h000) begin
        n_err++; $display("FAIL reset_mid idle cyc %0d got %h want %h", k, obs1, 12'h000);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < q.size(); i++) begin
      if1.START = q[i].start; if1.DIN_VALID = q[i].din_valid;
      if1.DOUT_READY = q[i].dout_ready;
      if1.NUM_ABSORB = q[i].na; if1.NUM_SQUEEZE = q[i].ns;
      @(negedge clk);
      n_cmp++;
      if (obs1 !== q[i].word) begin
        n_err++; $display("FAIL reset_mid rerun cyc %0d got %h want %h", i, obs1, q[i].word);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_start_while_busy();
    q.delete();
    build(2, 1, 6, 4, 0, 0, 1, 8'd2, 8'd1);
    for (int i = 0; i < q.size(); i++) begin
      // Extra START pulses and changed counts while busy must have no effect.
      if4.START = q[i].start || (i == 1) || (i == 5) || (i == 8) || (i == 16);
      if4.DIN_VALID = q[i].din_valid;
      if4.DOUT_READY = q[i].dout_ready;
      if4.NUM_ABSORB  = (i == 0) ? q[i].na : 8'd7;
      if4.NUM_SQUEEZE = (i == 0) ? q[i].ns : 8'd4;
      @(negedge clk);
      n_cmp++;
      if (obs4 !== q[i].word) begin
        n_err++; $display("FAIL start_busy cyc %0d got %h want %h", i, obs4, q[i].word);
      end
      if (i < q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    if4.START = 0;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    q.delete();
    build(1, 1, 6, 4, 0, 0, 0, 8'd1, 8'd1);
    build(1, 2, 6, 4, 0, 0, 1, 8'd1, 8'd2);
    for (int i = 0; i < q.size(); i++) begin
      if4.START = q[i].start; if4.DIN_VALID = q[i].din_valid;
      if4.DOUT_READY = q[i].dout_ready;
      if4.NUM_ABSORB = q[i].na; if4.NUM_SQUEEZE = q[i].ns;
      @(negedge clk);
      n_cmp++;
      if (obs4 !== q[i].word) begin
        n_err++; $display("FAIL back_to_back cyc %0d got %h want %h", i, obs4, q[i].word);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_minimal();
    test_multi_block();
    test_stalls();
    test_zero_counts();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
